pll_rst_seq: RTL

//  Reset sequencer directly downstream of PLL_25to200. Consumes the PLL LOCK output
//  and produces the synchronous system reset for logic clocked by one PLL output
//  (e.g. CLKOS2 = 50 MHz). Releases reset only after LOCK has been stable for a

---
 rtl/pll_rst_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pll_rst_seq.sv
// Reset sequencer behind the PLL: filters LOCK, holds the system reset, then releases into RUN.
// Latency: SYNC_STAGES edges pin-to-lock_s, then 1+LOCK_FILT+RST_HOLD edges to release sys_rst.
// Backpressure: none; free-running, driven only by the PLL LOCK level and the clr_lost pulse.
module pll_rst_seq #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILT   = 1024,
    parameter int RST_HOLD    = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_lock,
    input  logic             clr_lost,
    output logic             sys_rst,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lock_loss_cnt,
    output logic [1:0]       state_o
);

    localparam int MAX_WIN = (LOCK_FILT > RST_HOLD) ? LOCK_FILT : RST_HOLD;
    localparam int CW      = $clog2(MAX_WIN + 1);
    localparam logic [CW-1:0] FILT_LAST = CW'(LOCK_FILT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t               state, next_state;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 lock_s;
    logic                 loss_evt;

    assign lock_s  = sync_q[SYNC_STAGES-1];
    assign state_o = state;

    // pll_lock is asynchronous; only this chain may look at it
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
        end
    end

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        loss_evt   = 1'b0;
        case (state)
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = FILTER;
                    cnt_nxt    = '0;
                end
            end
            FILTER: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                    cnt_nxt    = '0;
                end else if (cnt == FILT_LAST) begin
                    next_state = HOLD;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                    cnt_nxt    = '0;
                end else if (cnt == HOLD_LAST) begin
                    next_state = RUN;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                    cnt_nxt    = '0;
                    loss_evt   = 1'b1;
                end
            end
            default: begin
                next_state = WAIT_LOCK;
                cnt_nxt    = '0;
            end
        endcase
    end

    // Outputs follow next_state so sys_rst/ready change on the same edge as the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            sys_rst <= 1'b1;
            ready   <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= cnt_nxt;
            sys_rst <= (next_state != RUN);
            ready   <= (next_state == RUN);
        end
    end

    // A loss in the same cycle as clr_lost restarts the count from the cleared value
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
        end else if (loss_evt) begin
            lock_lost <= 1'b1;
            if (clr_lost) begin
                lock_loss_cnt <= CNT_W'(1);
            end else if (lock_loss_cnt != {CNT_W{1'b1}}) begin
                lock_loss_cnt <= lock_loss_cnt + CNT_W'(1);
            end
        end else if (clr_lost) begin
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
        end
    end

endmodule
